// File: rtl/alu_seq.sv
// alu_seq -- multi-cycle handshaked ALU: add, sub, shift-add multiply, restoring divide.
// Two operands are picked from NCH input channels and produce a 2*WIDTH-bit result.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   cmd_valid  command present
//   cmd_ready  block can accept a command (state IDLE)
//   cmdin      {a_sel, b_sel, op}; op 0 add, 1 sub, 2 mul, 3 div
//   din        channel k = din[k*WIDTH +: WIDTH]
//   res_valid  result valid (state DONE)
//   res_ready  consumer takes the result
//   dout_low   result low half; quotient for div
//   dout_high  result high half; remainder for div
//   zero       result is zero and no error
//   error      divide by zero or channel select out of range
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// EXEC  | operands captured; iterating (mul/div) or one settle cycle (add/sub/error)
// DONE  | result registered and held until res_ready

module alu_seq #(
   parameter int WIDTH = 8,
   parameter int NCH   = 3,
   parameter int SEL_W = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [2*SEL_W+1:0]     cmdin,
   input  logic [NCH*WIDTH-1:0]   din,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [WIDTH-1:0]       dout_low,
   output logic [WIDTH-1:0]       dout_high,
   output logic                   zero,
   output logic                   error
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0]   a_q, b_q;
   logic [1:0]         op_q;
   logic               err_q;
   logic [CNT_W-1:0]   cnt_q;
   // p_hi/p_lo: partial product / multiplier for mul, remainder / dividend-quotient for div
   logic [WIDTH-1:0]   p_hi_q, p_lo_q;

   logic [SEL_W-1:0]   a_sel, b_sel;
   logic [1:0]         op_in;
   logic [WIDTH-1:0]   a_val, b_val;
   logic               sel_bad, err_in, accept;

   logic [WIDTH:0]     mul_sum, div_shift, div_trial;
   logic [WIDTH-1:0]   iter_hi, iter_lo;
   logic [2*WIDTH-1:0] res_full;

   assign op_in  = cmdin[1:0];
   assign b_sel  = cmdin[SEL_W+1:2];
   assign a_sel  = cmdin[2*SEL_W+1:SEL_W+2];
   assign accept = cmd_valid && (state_q == IDLE);

   always_comb begin
      a_val = '0;
      b_val = '0;
      for (int k = 0; k < NCH; k++) begin
         if (a_sel == SEL_W'(k)) a_val = din[k*WIDTH +: WIDTH];
         if (b_sel == SEL_W'(k)) b_val = din[k*WIDTH +: WIDTH];
      end
   end

   assign sel_bad = (int'(a_sel) >= NCH) || (int'(b_sel) >= NCH);
   assign err_in  = sel_bad || ((op_in == OP_DIV) && (b_val == '0));

   // One iteration step of shift-add multiply or restoring divide.
   always_comb begin
      mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, a_q} : '0);
      div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, b_q};
      iter_hi   = '0;
      iter_lo   = '0;
      if (op_q == OP_MUL) begin
         iter_hi = mul_sum[WIDTH:1];
         iter_lo = {mul_sum[0], p_lo_q[WIDTH-1:1]};
      end else begin
         // MSB of the trial difference set means the divisor did not fit: restore.
         if (div_trial[WIDTH]) begin
            iter_hi = div_shift[WIDTH-1:0];
            iter_lo = {p_lo_q[WIDTH-2:0], 1'b0};
         end else begin
            iter_hi = div_trial[WIDTH-1:0];
            iter_lo = {p_lo_q[WIDTH-2:0], 1'b1};
         end
      end
   end

   always_comb begin
      res_full = '0;
      case (op_q)
         OP_ADD:  res_full = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
         OP_SUB:  res_full = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
         default: res_full = {p_hi_q, p_lo_q};
      endcase
      if (err_q) res_full = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    if (cnt_q == '0) state_d = DONE;
         DONE:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == IDLE);
      res_valid = (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_ADD;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         p_hi_q    <= '0;
         p_lo_q    <= '0;
         dout_low  <= '0;
         dout_high <= '0;
         zero      <= 1'b0;
         error     <= 1'b0;
      end else if (accept) begin
         a_q    <= a_val;
         b_q    <= b_val;
         op_q   <= op_in;
         err_q  <= err_in;
         p_hi_q <= '0;
         p_lo_q <= (op_in == OP_DIV) ? a_val : b_val;
         // Only error-free mul/div iterate; everything else settles in one EXEC cycle.
         cnt_q  <= (op_in[1] && !err_in) ? CNT_W'(WIDTH) : '0;
      end else if (state_q == EXEC) begin
         if (cnt_q != '0) begin
            p_hi_q <= iter_hi;
            p_lo_q <= iter_lo;
            cnt_q  <= cnt_q - 1'b1;
         end else begin
            dout_low  <= res_full[WIDTH-1:0];
            dout_high <= res_full[2*WIDTH-1:WIDTH];
            zero      <= (res_full == '0) && !err_q;
            error     <= err_q;
         end
      end
   end

endmodule
